// File: rtl/out_frame_sequencer.sv
// out_frame_sequencer: fills the 64-bit host output buffer one frame at a time.
// Each frame is a header word followed by FRAME_WORDS payload words. The payload words
// come from two producers, and the producers are served round-robin. The full frame is
// then held for the host, which either finishes it or asks for it to be read again.
module out_frame_sequencer #(
  parameter int unsigned FRAME_WORDS = 4,
  parameter int unsigned DATA_W      = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [DATA_W-1:0] buf_data,
  output logic              buf_wr,
  output logic              buf_clear,
  output logic              buf_rewind,
  output logic              data_ready,
  input  logic              host_finish,
  input  logic              host_retransmit,
  output logic [15:0]       frame_seq
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HEADER = 2'd1;
  localparam logic [1:0] FILL   = 2'd2;
  localparam logic [1:0] READY  = 2'd3;

  localparam logic [15:0] FrameWords = 16'(FRAME_WORDS);
  localparam logic [15:0] LastIdx    = 16'(FRAME_WORDS - 1);

  logic [1:0]        state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic              buf_wr_q, buf_wr_d;
  logic              buf_clear_q, buf_clear_d;
  logic              buf_rewind_q, buf_rewind_d;
  logic              data_ready_q, data_ready_d;
  logic [15:0]       frame_seq_q, frame_seq_d;
  logic              grant0, grant1;

  // Round-robin grant: a lone requester always wins; on contention the one not served last.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == FILL) begin
      if (req0_valid && (!req1_valid || last_grant_q)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req0_ready = grant0 & ~reset;
  assign req1_ready = grant1 & ~reset;

  // Next-state logic; the strobes default low so each one lasts exactly one cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    buf_data_d   = buf_data_q;
    buf_wr_d     = 1'b0;
    buf_clear_d  = 1'b0;
    buf_rewind_d = 1'b0;
    data_ready_d = data_ready_q;
    frame_seq_d  = frame_seq_q;
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          state_d     = HEADER;
          buf_clear_d = 1'b1;
        end
      end
      HEADER: begin
        state_d    = FILL;
        buf_wr_d   = 1'b1;
        buf_data_d = {16'hD0B1, frame_seq_q, FrameWords, 16'h0000};
      end
      FILL: begin
        if (grant0 || grant1) begin
          buf_wr_d     = 1'b1;
          buf_data_d   = grant1 ? req1_data : req0_data;
          last_grant_d = grant1;
          if (cnt_q == LastIdx) begin
            cnt_d        = 16'd0;
            state_d      = READY;
            data_ready_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      READY: begin
        // Finish takes priority over a retransmit in the same cycle.
        if (host_finish) begin
          data_ready_d = 1'b0;
          frame_seq_d  = frame_seq_q + 16'd1;
          state_d      = IDLE;
        end else if (host_retransmit) begin
          buf_rewind_d = 1'b1;
          data_ready_d = 1'b0;
        end else begin
          data_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 16'd0;
      last_grant_q <= 1'b1;
      buf_data_q   <= '0;
      buf_wr_q     <= 1'b0;
      buf_clear_q  <= 1'b0;
      buf_rewind_q <= 1'b0;
      data_ready_q <= 1'b0;
      frame_seq_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      buf_data_q   <= buf_data_d;
      buf_wr_q     <= buf_wr_d;
      buf_clear_q  <= buf_clear_d;
      buf_rewind_q <= buf_rewind_d;
      data_ready_q <= data_ready_d;
      frame_seq_q  <= frame_seq_d;
    end
  end

  assign buf_data   = buf_data_q;
  assign buf_wr     = buf_wr_q;
  assign buf_clear  = buf_clear_q;
  assign buf_rewind = buf_rewind_q;
  assign data_ready = data_ready_q;
  assign frame_seq  = frame_seq_q;

endmodule

// File: tb/tb_out_frame_sequencer.sv
// Bench for out_frame_sequencer. It runs a table of single-producer vectors, then directed
// corner-case sequences and a randomized run. A frame-level reference model checks every cycle.
module tb_out_frame_sequencer;

  localparam int unsigned FW = 4;

  logic        clk = 1'b0;
  logic        reset, req0_valid, req1_valid, req0_ready, req1_ready;
  logic [63:0] req0_data, req1_data, buf_data;
  logic        buf_wr, buf_clear, buf_rewind, data_ready, host_finish, host_retransmit;
  logic [15:0] frame_seq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  out_frame_sequencer #(.FRAME_WORDS(FW), .DATA_W(64)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .buf_data(buf_data), .buf_wr(buf_wr), .buf_clear(buf_clear), .buf_rewind(buf_rewind),
    .data_ready(data_ready), .host_finish(host_finish), .host_retransmit(host_retransmit),
    .frame_seq(frame_seq)
  );

  // Reference model: where the current frame stands, plus the outputs that are expected.
  typedef enum int {MIdle, MClear, MFill, MHold} mphase_e;
  mphase_e     ph = MIdle;
  int unsigned words = 0;
  int          last_srv = 1;
  logic [15:0] seq = 16'd0;
  logic        e_wr = 1'b0, e_clear = 1'b0, e_rewind = 1'b0, e_dr = 1'b0;
  logic [63:0] e_data = 64'd0;

  // Observations of the bench, used by the directed checks.
  logic        got_r0, got_r1;
  int          n_wr = 0, n_rewind = 0, n_drlow = 0;
  logic [63:0] wq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Which producer should be served: a lone requester; on contention, the one not served last.
  function automatic int pick(input logic v0, input logic v1);
    if (v0 && v1) return (last_srv == 0) ? 1 : 0;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  // Runs one clock cycle. It drives the inputs, checks the readies, steps the model and
  // checks the registered outputs.
  task automatic cycle(input logic rs, input logic v0, input logic v1, input logic [63:0] d0,
                       input logic [63:0] d1, input logic fin, input logic rtx);
    int win;
    reset = rs; req0_valid = v0; req1_valid = v1; req0_data = d0; req1_data = d1;
    host_finish = fin; host_retransmit = rtx;
    #1;
    win = (!rs && ph == MFill) ? pick(v0, v1) : -1;
    got_r0 = req0_ready;
    got_r1 = req1_ready;
    chk("req0_ready", 64'(req0_ready), 64'(win == 0));
    chk("req1_ready", 64'(req1_ready), 64'(win == 1));
    @(posedge clk);
    if (rs) begin
      ph = MIdle; words = 0; seq = 16'd0; last_srv = 1;
      e_wr = 1'b0; e_clear = 1'b0; e_rewind = 1'b0; e_dr = 1'b0; e_data = 64'd0;
    end else begin
      e_wr = 1'b0; e_clear = 1'b0; e_rewind = 1'b0;
      case (ph)
        MIdle: if (v0 || v1) begin ph = MClear; e_clear = 1'b1; end
        MClear: begin
          ph = MFill; e_wr = 1'b1;
          e_data = {16'hD0B1, seq, 16'(FW), 16'h0000};
        end
        MFill: if (win >= 0) begin
          e_wr = 1'b1; e_data = (win == 1) ? d1 : d0; last_srv = win; words++;
          if (words == FW) begin words = 0; ph = MHold; e_dr = 1'b1; end
        end
        MHold: begin
          if (fin) begin e_dr = 1'b0; seq++; ph = MIdle; end
          else if (rtx) begin e_rewind = 1'b1; e_dr = 1'b0; end
          else e_dr = 1'b1;
        end
        default: ph = MIdle;
      endcase
    end
    @(negedge clk);
    chk("buf_wr", 64'(buf_wr), 64'(e_wr));
    chk("buf_clear", 64'(buf_clear), 64'(e_clear));
    chk("buf_rewind", 64'(buf_rewind), 64'(e_rewind));
    chk("data_ready", 64'(data_ready), 64'(e_dr));
    chk("buf_data", buf_data, e_data);
    chk("frame_seq", 64'(frame_seq), 64'(seq));
    if (buf_wr) begin n_wr++; wq.push_back(buf_data); end
    if (buf_rewind) n_rewind++;
    if (!data_ready) n_drlow++;
  endtask

  typedef struct {
    logic        v0;
    logic [63:0] d0;
    logic        fin;
    logic        r0;    // expected req0_ready during the cycle
    logic        wr;    // expected registered outputs after the edge
    logic        clr;
    logic        dr;
    logic [63:0] data;
    logic [15:0] seq;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [63:0] w0, w1, w2, w3, hdr0;
    logic [3:0]  nib;
    int          base_wr, base_rw, base_dl;
    w0 = 64'hFFFFFFFF00000000; w1 = 64'h00000000FFFFFFFF;
    w2 = 64'hFFFF00000000FFFF; w3 = 64'hFFFFFFFF00000000;
    hdr0 = 64'hD0B1_0000_0004_0000;
    tbl[0] = '{1'b1, w0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 16'h0};
    tbl[1] = '{1'b1, w0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, hdr0,  16'h0};
    tbl[2] = '{1'b1, w0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, w0,    16'h0};
    tbl[3] = '{1'b1, w1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, w1,    16'h0};
    tbl[4] = '{1'b1, w2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, w2,    16'h0};
    tbl[5] = '{1'b1, w3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, w3,    16'h0};
    tbl[6] = '{1'b1, w0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, w3,    16'h0};
    tbl[7] = '{1'b0, w0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, w3,    16'h1};

    // Reset, then the single-producer frame from the table.
    cycle(1'b1, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, tbl[i].v0, 1'b0, tbl[i].d0, 64'd0, tbl[i].fin, 1'b0);
      chk($sformatf("tbl[%0d] req0_ready", i), 64'(got_r0), 64'(tbl[i].r0));
      chk($sformatf("tbl[%0d] req1_ready", i), 64'(got_r1), 64'd0);
      chk($sformatf("tbl[%0d] buf_wr", i), 64'(buf_wr), 64'(tbl[i].wr));
      chk($sformatf("tbl[%0d] buf_clear", i), 64'(buf_clear), 64'(tbl[i].clr));
      chk($sformatf("tbl[%0d] data_ready", i), 64'(data_ready), 64'(tbl[i].dr));
      chk($sformatf("tbl[%0d] buf_data", i), buf_data, tbl[i].data);
      chk($sformatf("tbl[%0d] frame_seq", i), 64'(frame_seq), 64'(tbl[i].seq));
    end

    // Contention from a fresh reset: the payload must alternate A,B,A,B.
    cycle(1'b1, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    wq.delete();
    for (int i = 0; i < 6; i++)
      cycle(1'b0, 1'b1, 1'b1, 64'hA000_0000_0000_0000 | 64'(i),
            64'hB000_0000_0000_0000 | 64'(i), 1'b0, 1'b0);
    chk("contention writes", 64'(wq.size()), 64'd5);
    if (wq.size() == 5) begin
      chk("contention header", wq[0], hdr0);
      for (int k = 1; k < 5; k++) begin
        nib = wq[k][63:60];
        chk($sformatf("contention word %0d", k), 64'(nib), (k % 2 == 1) ? 64'hA : 64'hB);
      end
    end

    // Two retransmits three cycles apart while the frame is held.
    base_wr = n_wr; base_rw = n_rewind; base_dl = n_drlow;
    for (int i = 0; i < 6; i++)
      cycle(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1 && (i % 3 == 0));
    chk("retx rewinds", 64'(n_rewind - base_rw), 64'd2);
    chk("retx data_ready low cycles", 64'(n_drlow - base_dl), 64'd2);
    chk("retx writes", 64'(n_wr - base_wr), 64'd0);
    chk("retx frame_seq", 64'(frame_seq), 64'd0);

    // Finish and retransmit together: finish wins and there is no rewind.
    cycle(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b1, 1'b1);
    chk("fin+retx rewind", 64'(buf_rewind), 64'd0);
    chk("fin+retx frame_seq", 64'(frame_seq), 64'd1);
    cycle(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    chk("fin+retx idle clear", 64'(buf_clear), 64'd0);

    // Stall: producer 0 drops valid for 5 cycles after two payload words.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 64'h1111 * 64'(i), 64'd0, 1'b0, 1'b0);
    base_wr = n_wr;
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    chk("stall writes", 64'(n_wr - base_wr), 64'd0);
    chk("stall data_ready", 64'(data_ready), 64'd0);
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 1'b0, 64'h2222 * 64'(i + 1), 64'd0, 1'b0, 1'b0);
    chk("stall completes", 64'(data_ready), 64'd1);
    cycle(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b1, 1'b0);

    // Third frame from producer 1 alone; its header must carry sequence 2.
    wq.delete();
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1, 64'd0, 64'h3333 * 64'(i), 1'b0, 1'b0);
    chk("frame 3 header", (wq.size() > 0) ? wq[0] : 64'hX, 64'hD0B1_0002_0004_0000);
    cycle(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b1, 1'b0);

    // Reset after two payload words, then a new frame must start at sequence 0.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 64'h4444 * 64'(i), 64'd0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 64'h5555, 64'd0, 1'b0, 1'b0);
    chk("rst buf_wr", 64'(buf_wr), 64'd0);
    chk("rst buf_data", buf_data, 64'd0);
    chk("rst data_ready", 64'(data_ready), 64'd0);
    chk("rst frame_seq", 64'(frame_seq), 64'd0);
    chk("rst req0_ready", 64'(got_r0), 64'd0);
    cycle(1'b0, 1'b1, 1'b0, 64'h6666, 64'd0, 1'b0, 1'b0);
    chk("post-rst clear", 64'(buf_clear), 64'd1);
    cycle(1'b0, 1'b1, 1'b0, 64'h6666, 64'd0, 1'b0, 1'b0);
    chk("post-rst header", buf_data, hdr0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 399) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            {$urandom, $urandom}, {$urandom, $urandom},
            $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/out_frame_sequencer.md
# out_frame_sequencer

Sequences the 64-bit word buffer that feeds the 16-bit host output interface. Arbitrates round-robin between two Doppler data producers, prefixes each frame with a header word, writes header plus `FRAME_WORDS` payload words into the output buffer, and then holds the buffer for the host. The host-side interface reports completion (`host_finish`) or asks for a resend (`host_retransmit`). Sits between the processing channels and the output buffer and host interface.

## Interface
- `FRAME_WORDS`, 4: payload words per frame; valid range 1..65535.
- `DATA_W`, 64: buffer word width; fixed at 64 for the header format.
- `clk` in 1: system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req0_valid` in 1: producer 0 has a word.
- `req0_data` in 64: producer 0 word.
- `req0_ready` out 1: producer 0 word accepted this cycle when valid is also high.
- `req1_valid`, `req1_data`, `req1_ready`: same as producer 0, for producer 1.
- `buf_data` out 64: word to the output buffer.
- `buf_wr` out 1: one-cycle write strobe for `buf_data`; this is the buffer's next-word pulse.
- `buf_clear` out 1: one-cycle pulse that resets the buffer write/read pointers.
- `buf_rewind` out 1: one-cycle pulse that resets only the buffer read pointer.
- `data_ready` out 1: level; a complete frame is in the buffer.
- `host_finish` in 1: one-cycle pulse from the host interface meaning the frame has been fully read.
- `host_retransmit` in 1: one-cycle pulse meaning the host requests a resend.
- `frame_seq` out 16: sequence number of the current or last frame.

## Operation
- States: IDLE, HEADER, FILL, READY.
- **IDLE**
  - Both `req*_ready` are 0.
  - If `req0_valid | req1_valid` → HEADER.
  - Registered `buf_clear`=1 for exactly the HEADER cycle.
- **HEADER** (exactly 1 cycle) → FILL.
  - At this edge: `buf_wr`<=1 and `buf_data`<={16'hD0B1, frame_seq, FRAME_WORDS[15:0], 16'h0000}.
- **FILL**
  - Grant:
    - Only one valid: grant it.
    - Both valid: grant the requester not granted last (`last_grant` register, resets to 1 so producer 0 wins first).
    - `reqN_ready` = (state==FILL) & (grant==N). Combinational from state, `last_grant` and the valids.
    - At most one ready high per cycle; ready never high when that producer's valid is low.
  - Acceptance (`valid & ready` at edge):
    - `buf_data`<=word unchanged, `buf_wr`<=1, `last_grant`<=N, `cnt`<=cnt+1.
  - No acceptance: `buf_wr`<=0 and `buf_data` holds.
  - When the accepted word is number `FRAME_WORDS` (cnt==FRAME_WORDS-1 before the increment): → READY, `data_ready`<=1, `cnt`<=0.
- **READY**
  - No acceptances.
  - `host_retransmit`:
    - `buf_rewind`<=1 for one cycle, `data_ready`<=0 for that same cycle, then `data_ready` returns to 1.
    - Stay in READY, unlimited times.
  - `host_finish`: `data_ready`<=0, `frame_seq`<=frame_seq+1 (wraps 16'hFFFF→0), → IDLE.
  - `host_finish` and `host_retransmit` in the same cycle: finish wins, no rewind.
- `host_finish` / `host_retransmit` outside READY are ignored.
- `cnt` is 16 bits and never exceeds FRAME_WORDS-1.

## Timing
- Reset values: state IDLE, `buf_data`=0, `buf_wr`=0, `buf_clear`=0, `buf_rewind`=0, `data_ready`=0, `frame_seq`=0, `cnt`=0, `last_grant`=1.
- `req*_ready` is 0 during reset.
- Reset mid-frame:
  - Abandons the frame; the next frame restarts with a clear and header.
  - `frame_seq` returns to 0.
- Valid sampled in IDLE at edge E0:
  - Cycle E0..E1: `buf_clear`=1.
  - Cycle E1..E2: header on `buf_wr`, state FILL, ready may assert.
- Payload word accepted at edge Ek appears on `buf_data` / `buf_wr` in cycle Ek..Ek+1 (1-cycle latency).
- `data_ready` rises in the same cycle as the last payload `buf_wr`.
- Minimum frame period: FRAME_WORDS+2 cycles plus the host hold time.
- Output pulses (`buf_wr`, `buf_clear`, `buf_rewind`) are exactly 1 cycle; `buf_clear` and `buf_wr` are never high together.
- `host_finish` at edge F: `data_ready`=0 from F.
  - Earliest next `buf_clear` is at edge F+1, if a valid is present in IDLE.

## Test plan
- **Single producer:**
  - Stimulus: `req0_valid`=1 continuously, data 0xFFFFFFFF00000000, 0x00000000FFFFFFFF, 0xFFFF00000000FFFF, 0xFFFFFFFF00000000.
  - Required:
    - `buf_clear` pulse, then header 0xD0B1_0000_0004_0000.
    - The 4 words on consecutive `buf_wr` cycles.
    - `data_ready`=1 with the 4th write.
    - `req0_ready`=0 afterward.
- **Contention:**
  - Stimulus: both valid continuously, req0 data = 0xA…, req1 data = 0xB….
  - Required: payload order A,B,A,B, and never both readies high.
- **Retransmit:**
  - Stimulus: in READY, pulse `host_retransmit` twice, 3 cycles apart.
  - Required:
    - Two 1-cycle `buf_rewind` pulses, `data_ready` low exactly 1 cycle each.
    - No `buf_wr`, `frame_seq` unchanged.
- **Finish and sequence:**
  - Stimulus: complete 3 frames with `host_finish`; include one cycle with finish and retransmit together.
  - Required:
    - Headers carry seq 0, 1, 2.
    - The simultaneous cycle produces no rewind and returns to IDLE.
- **Stall:**
  - Stimulus: drop `req0_valid` for 5 cycles after 2 words.
  - Required: `buf_wr` low for those cycles, frame completes after the remaining 2 words, `cnt` correct.
- **Reset mid-frame:**
  - Stimulus: assert `reset` after 2 payload words.
  - Required:
    - All outputs are at their reset values on the next cycle.
    - The next frame starts with `buf_clear` and a header with seq 0.
